// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned LEN_W          = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link from the host byte source into the loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted data bytes little-endian into 32-bit words and keeps a running XOR.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [7:0]  xor_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       word_q, word_d;
    logic              valid_q, valid_d;
    logic [7:0]        xor_q, xor_d;
    logic [31:0]       merged;

    // Lane insertion, word completion and running checksum.
    always_comb begin
        merged = acc_q;
        merged[8 * lane_q +: 8] = byte_i;
        last_byte_o = byte_en_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
        lane_d  = lane_q;
        acc_d   = acc_q;
        xor_d   = xor_q;
        word_d  = word_q;
        // A word completed in the same cycle as a restart is still written out.
        valid_d = last_byte_o;
        if (last_byte_o) begin
            word_d = merged;
        end
        if (clear_i) begin
            lane_d = '0;
            acc_d  = '0;
            xor_d  = '0;
        end else if (byte_en_i) begin
            lane_d = lane_q + LANE_W'(1);
            acc_d  = last_byte_o ? 32'h0 : merged;
            xor_d  = xor_q ^ byte_i;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            xor_q   <= '0;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            xor_q   <= xor_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;
    assign xor_o        = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that streams a length-prefixed, XOR-checked image into instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    imem_loader_if.slave      bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_full;
    logic              accept;
    logic              data_en;
    logic              last_byte;
    logic              word_valid;
    logic [7:0]        run_xor;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (load_start),
        .byte_en_i    (data_en),
        .byte_i       (bus.in_data),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (mem_wdata),
        .xor_o        (run_xor)
    );

    // Next-state, length capture and word-index bookkeeping.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        words_d  = words_q;
        addr_d   = addr_q;
        accept   = bus.in_valid && bus.in_ready;
        data_en  = accept && (state_q == S_DATA);
        len_full = {bus.in_data, len_q[7:0]};
        unique case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > DEPTH) begin
                        state_d = S_ERR;
                    end else if (len_full == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    addr_d  = words_q[ADDR_W-1:0];
                    words_d = words_q + 16'd1;
                    if (words_q == len_q - LEN_W'(1)) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (bus.in_data == run_xor) ? S_DONE : S_ERR;
                end
            end
            default: ;
        endcase
        if (load_start) begin
            state_d = S_LEN_LO;
            len_d   = '0;
            words_d = '0;
        end
    end

    // Loader state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

    // Status and handshake outputs decoded from the registered state only.
    always_comb begin
        bus.in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
        cpu_hold     = (state_q != S_IDLE) && (state_q != S_DONE);
        load_done    = (state_q == S_DONE);
        load_error   = (state_q == S_ERR);
        mem_we       = word_valid && (32'(addr_q) < DEPTH);
        mem_addr     = addr_q;
        words_loaded = words_q;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words and issues one-cycle word writes to the instruction memory's write port. Holds the core in reset while loading and reports completion or error. Sits between the host-link byte source (UART RX or testbench) and the instruction memory.

Parameters:
DEPTH, 64, number of 32-bit words in instruction memory
ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load_start  input  1  one-cycle pulse; begins or restarts a load
in_valid  input  1  byte source has a byte
in_data  input  8  byte value
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction-memory word write enable (one-cycle pulse)
mem_addr  output  ADDR_W  word index written
mem_wdata  output  32  word written
cpu_hold  output  1  keep core in reset while high
load_done  output  1  sticky: load finished, checksum good
load_error  output  1  sticky: length overflow or checksum mismatch
words_loaded  output  16  count of words written in current load

Behaviour:
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes, 1 checksum byte = XOR of all data bytes (length bytes excluded).
- A byte is accepted only on a cycle with in_valid && in_ready. in_ready is registered-state based: 1 in S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK; 0 otherwise. in_ready does not depend combinationally on in_valid.
- States: S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR.
- S_IDLE --load_start--> S_LEN_LO. S_LEN_LO --byte--> S_LEN_HI. S_LEN_HI --byte--> S_ERR if N > DEPTH; S_CHECK if N == 0; else S_DATA.
- S_DATA: byte lane counter 0..3; byte k goes to wdata[8k+7:8k]. On 4th byte accepted, mem_we=1 on the NEXT cycle with mem_addr=word index, mem_wdata=packed word. Word index starts at 0 and increments after each write; words_loaded increments in the same cycle as mem_we. After word N-1's 4th byte -> S_CHECK (the final mem_we occurs in the first S_CHECK cycle).
- S_CHECK --byte--> S_DONE if byte equals running XOR, else S_ERR.
- S_DONE: load_done=1, cpu_hold=0. S_ERR: load_error=1, cpu_hold=1. Both remain until load_start or rst.
- cpu_hold: 1 from the cycle after load_start through all loading states; 0 in S_IDLE and S_DONE.
- load_start in any state (including mid-frame): abort, go to S_LEN_LO next cycle; clear lane counter, word index, XOR, words_loaded, load_done, load_error; no mem_we issued for a partial word. A pending mem_we from a word completed in the same cycle as load_start is still issued.
- in_valid with in_ready=0: byte ignored, no state change.
- mem_we is never asserted for address >= DEPTH.
- Reset (any time, incl. mid-load): state S_IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_error=0, words_loaded=0, internal counters/XOR=0.

Decomposition:
- Package imem_loader_pkg: state encoding constants (S_IDLE..S_ERR), frame constants (BYTES_PER_WORD=4, LEN_BYTES=2).
- One sub-module: imem_word_packer (byte lane counter, shift/pack into 32-bit word, emits word_valid pulse and running XOR); imem_loader holds FSM, length, address counter and status.

Test Plan:
- Load N=2: bytes 02 00 | 13 00 00 00 | 93 00 50 00 | D0 -> mem_we at addr 0 with 0x00000013, addr 1 with 0x00500093; load_done=1, load_error=0, words_loaded=2, cpu_hold falls to 0.
- Same frame with checksum 0xD1 -> both writes occur, load_error=1, load_done=0, cpu_hold stays 1.
- N=0: bytes 00 00 | 00 -> no mem_we, load_done=1; N=65 (41 00) -> S_ERR after 2nd byte, in_ready=0, no mem_we.
- Backpressure: the N=2 frame with in_valid toggled 1/0 each cycle and random gaps -> identical writes and status as the first scenario.
- Restart: load_start after 6 data bytes of an N=2 frame, then full N=1 frame 01 00 | EF BE AD DE | 22 -> only the write 0xDEADBEEF to addr 0 (plus the word-0 write completed before restart), words_loaded=1, load_done=1.
- rst asserted mid-data -> next cycle all outputs 0, state idle; subsequent bytes with in_valid=1 are ignored until load_start.
